// File: rtl/board_io_frontend.sv
// Board I/O front end: synchronises and debounces switches/buttons, emits press pulses,
// and scans a multiplexed 7-segment display with per-slot anode dead time.
module board_io_frontend #(
    parameter int NUM_SW          = 8,
    parameter int NUM_BTN         = 4,
    parameter int NUM_DIGITS      = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REFRESH_CYCLES  = 50000,
    parameter int DEAD_CYCLES     = 16
) (
    input  logic                    system1000,
    input  logic                    system1000_rst,
    input  logic [NUM_SW-1:0]       sw_in,
    input  logic [NUM_BTN-1:0]      btn_in,
    output logic [NUM_SW-1:0]       sw,
    output logic [NUM_BTN-1:0]      btn,
    output logic [NUM_BTN-1:0]      btn_press,
    input  logic [8*NUM_DIGITS-1:0] disp_data,
    input  logic [NUM_DIGITS-1:0]   disp_blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg
);

    localparam int NB = NUM_SW + NUM_BTN;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] CNT_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [RW-1:0] DEAD_END = RW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [NB-1:0] sync_q [SYNC_STAGES];
    logic [NB-1:0] synced;
    logic [NB-1:0] db_state;
    logic [CW-1:0] db_cnt [NB];
    logic [NUM_BTN-1:0] btn_prev;

    logic [RW-1:0]         slot_cnt;
    logic [IW-1:0]         idx;
    logic [NUM_DIGITS-1:0] an_d;
    logic [7:0]            seg_d;

    // Switches and buttons share one synchroniser/debounce array: {btn, sw}.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= {btn_in, sw_in};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            db_state <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (synced[i] == db_state[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_state[i] <= synced[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign sw  = db_state[NUM_SW-1:0];
    assign btn = db_state[NB-1:NUM_SW];

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            btn_prev <= '0;
        end else begin
            btn_prev <= btn;
        end
    end

    assign btn_press = btn & ~btn_prev;

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else if (slot_cnt == CNT_LAST) begin
            slot_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            slot_cnt <= slot_cnt + RW'(1);
        end
    end

    // Data and blanking are sampled live every cycle, not latched per slot.
    always_comb begin
        an_d  = '1;
        seg_d = '1;
        if (!(slot_cnt < DEAD_END) && !disp_blank[idx]) begin
            an_d[idx] = 1'b0;
            seg_d     = ~disp_data[8*idx +: 8];
        end
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            an  <= '1;
            seg <= '1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
        end
    end

endmodule

// File: tb/tb_board_io_frontend.sv
// Bench for board_io_frontend: expectations are queued with a due cycle when stimulus
// is driven and compared on the falling edge of that cycle.
module tb_board_io_frontend;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sw_in;
    logic [3:0]  btn_in;
    logic [7:0]  sw;
    logic [3:0]  btn;
    logic [3:0]  btn_press;
    logic [31:0] disp_data;
    logic [3:0]  disp_blank;
    logic [3:0]  an;
    logic [7:0]  seg;

    always #5 clk = ~clk;

    board_io_frontend #(
        .NUM_SW(8),
        .NUM_BTN(4),
        .NUM_DIGITS(4),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .REFRESH_CYCLES(8),
        .DEAD_CYCLES(2)
    ) dut (
        .system1000(clk),
        .system1000_rst(rst),
        .sw_in(sw_in),
        .btn_in(btn_in),
        .sw(sw),
        .btn(btn),
        .btn_press(btn_press),
        .disp_data(disp_data),
        .disp_blank(disp_blank),
        .an(an),
        .seg(seg)
    );

    typedef enum int {K_SW, K_BTN, K_PRESS, K_AN, K_SEG} kind_t;

    typedef struct {
        int unsigned due;
        kind_t       kind;
        logic [7:0]  val;
        string       name;
    } exp_t;

    typedef struct {
        logic [3:0] blank;
        int         digit;
        logic [3:0] an;
        logic [7:0] seg;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        vecs[8];
    int unsigned cyc = 0;
    int unsigned rel = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(input kind_t k);
        case (k)
            K_SW:    return sw;
            K_BTN:   return {4'b0, btn};
            K_PRESS: return {4'b0, btn_press};
            K_AN:    return {4'b0, an};
            default: return seg;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].due <= cyc) begin
                n_tests++;
                if (exp_q[i].due < cyc) begin
                    n_fail++;
                    $display("FAIL %s: expectation due at cycle %0d was never compared", exp_q[i].name, exp_q[i].due);
                end else if (actual(exp_q[i].kind) !== exp_q[i].val) begin
                    n_fail++;
                    $display("FAIL %s @cycle %0d: got %h, expected %h",
                             exp_q[i].name, cyc, actual(exp_q[i].kind), exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int unsigned off, input kind_t k, input logic [7:0] v, input string nm);
        exp_t e;
        e.due  = cyc + off;
        e.kind = k;
        e.val  = v;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic expect_disp(input int unsigned off, input logic [3:0] a, input logic [7:0] s, input string nm);
        expect_at(off, K_AN, {4'b0, a}, {nm, "_an"});
        expect_at(off, K_SEG, s, {nm, "_seg"});
    endtask

    // Advance until the next edge is the first of the given scan phase (0..31).
    task automatic align(input int unsigned ph);
        int unsigned n = 0;
        while (((cyc - rel) % 32) != ph && n < 64) begin
            tick();
            n++;
        end
        n_tests++;
        if (((cyc - rel) % 32) != ph) begin
            n_fail++;
            $display("FAIL align: phase %0d, expected %0d", (cyc - rel) % 32, ph);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'b0000, 0, 4'b1110, 8'hC0};
        vecs[1] = '{4'b0000, 1, 4'b1101, 8'hF9};
        vecs[2] = '{4'b0000, 2, 4'b1011, 8'hA4};
        vecs[3] = '{4'b0000, 3, 4'b0111, 8'hB0};
        vecs[4] = '{4'b0100, 0, 4'b1110, 8'hC0};
        vecs[5] = '{4'b0100, 1, 4'b1101, 8'hF9};
        vecs[6] = '{4'b0100, 2, 4'b1111, 8'hFF};
        vecs[7] = '{4'b0100, 3, 4'b0111, 8'hB0};

        // 1: reset with every input high
        rst        = 1'b1;
        sw_in      = '1;
        btn_in     = '1;
        disp_data  = '1;
        disp_blank = '1;
        for (int unsigned k = 1; k <= 4; k++) begin
            expect_at(k, K_SW, 8'h00, "t1_sw");
            expect_at(k, K_BTN, 8'h00, "t1_btn");
            expect_at(k, K_PRESS, 8'h00, "t1_press");
            expect_disp(k, 4'b1111, 8'hFF, "t1");
        end
        repeat (3) tick();
        rst = 1'b0;
        rel = cyc;
        tick();
        sw_in  = '0;
        btn_in = '0;
        repeat (10) tick();

        // 2: 3-cycle glitch, 5 low, then held
        btn_in[0] = 1'b1;
        for (int unsigned k = 1; k <= 17; k++) begin
            expect_at(k, K_BTN, (k >= 14) ? 8'h01 : 8'h00, "t2_btn");
            expect_at(k, K_PRESS, (k == 14) ? 8'h01 : 8'h00, "t2_press");
        end
        repeat (3) tick();
        btn_in[0] = 1'b0;
        repeat (5) tick();
        btn_in[0] = 1'b1;
        repeat (10) tick();

        // 3: release and switch pattern
        btn_in[0] = 1'b0;
        sw_in     = 8'hA5;
        for (int unsigned k = 1; k <= 9; k++) begin
            expect_at(k, K_BTN, (k >= 6) ? 8'h00 : 8'h01, "t3_btn");
            expect_at(k, K_PRESS, 8'h00, "t3_press");
            expect_at(k, K_SW, (k >= 6) ? 8'hA5 : 8'h00, "t3_sw");
        end
        repeat (10) tick();

        // 4/5: scan table, plain and with digit 2 blanked
        disp_data  = {8'h4F, 8'h5B, 8'h06, 8'h3F};
        disp_blank = '0;
        for (int i = 0; i < 8; i++) begin
            align(32'(vecs[i].digit * 8));
            disp_blank = vecs[i].blank;
            for (int unsigned k = 1; k <= 8; k++) begin
                if (k <= 2) expect_disp(k, 4'b1111, 8'hFF, "t45_dead");
                else        expect_disp(k, vecs[i].an, vecs[i].seg, "t45_lit");
            end
            tick();
        end
        repeat (8) tick();

        // 6: reset mid digit-2 slot with btn_in[1] mid-debounce
        disp_blank = '0;
        align(16);
        btn_in[1] = 1'b1;
        expect_disp(4, 4'b1011, 8'hA4, "t6_pre");
        repeat (4) tick();
        rst = 1'b1;
        expect_disp(1, 4'b1111, 8'hFF, "t6_rst");
        expect_at(1, K_BTN, 8'h00, "t6_rst_btn");
        expect_at(1, K_PRESS, 8'h00, "t6_rst_press");
        expect_at(1, K_SW, 8'h00, "t6_rst_sw");
        tick();
        rst = 1'b0;
        rel = cyc;
        for (int unsigned k = 1; k <= 8; k++) begin
            expect_at(k, K_BTN, (k >= 6) ? 8'h02 : 8'h00, "t6_btn");
            expect_at(k, K_PRESS, (k == 6) ? 8'h02 : 8'h00, "t6_press");
            expect_at(k, K_SW, (k >= 6) ? 8'hA5 : 8'h00, "t6_sw");
            if (k <= 2) expect_disp(k, 4'b1111, 8'hFF, "t6_dead0");
            else        expect_disp(k, 4'b1110, 8'hC0, "t6_lit0");
        end
        expect_disp(9, 4'b1111, 8'hFF, "t6_dead1");
        expect_disp(11, 4'b1101, 8'hF9, "t6_lit1");
        repeat (14) tick();

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
